// File: rtl/score_keeper.sv
// score_keeper: game-progress and scoring stage fed by the collision checker verdicts and the metronome beat.
// Ports: clk/rst (sync, active-high); metronome_clk/start (async, synchronised here); correctHit/incorrectHit (clk-domain levels);
//        outputs state, score, combo, best_combo, lives, beat_count, hit_pulse, miss_pulse -- all registered.
module score_keeper #(
    parameter int LIVES      = 5,
    parameter int SONG_BEATS = 64,
    parameter int SCORE_MAX  = 9999,
    parameter int COMBO_MAX  = 99
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        metronome_clk,
    input  logic        start,
    input  logic        correctHit,
    input  logic        incorrectHit,
    output logic [1:0]  state,
    output logic [13:0] score,
    output logic [6:0]  combo,
    output logic [6:0]  best_combo,
    output logic [2:0]  lives,
    output logic [7:0]  beat_count,
    output logic        hit_pulse,
    output logic        miss_pulse
);

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        IDLE = 2'd1,
        OVER = 2'd2,
        WIN  = 2'd3
    } state_t;

    localparam logic [14:0] SCORE_LIM = 15'(SCORE_MAX);
    localparam logic [6:0]  COMBO_LIM = 7'(COMBO_MAX);
    localparam logic [2:0]  LIVES_INI = 3'(LIVES);
    localparam logic [7:0]  BEATS_END = 8'(SONG_BEATS);

    // Asynchronous inputs: two-flop synchroniser plus previous-value flop.
    logic met_s1, met_s2, met_prev;
    logic start_s1, start_s2, start_prev;
    // Verdict levels: a sampling flop and a previous-value flop, so the
    // update lands one edge after the level is first sampled.
    logic hit_q, hit_prev, miss_q, miss_prev;

    logic met_rise, start_rise, hit_rise, miss_rise;

    state_t      state_q, state_d;
    logic [13:0] score_d;
    logic [6:0]  combo_d, best_d;
    logic [2:0]  lives_d;
    logic [7:0]  beat_d;
    logic        hit_pulse_d, miss_pulse_d;

    logic [2:0]  mult;
    logic [14:0] score_sum;
    logic [6:0]  combo_inc;
    logic [7:0]  beat_next;
    logic        last_life_lost;

    assign met_rise   = met_s2 & ~met_prev;
    assign start_rise = start_s2 & ~start_prev;
    assign hit_rise   = hit_q & ~hit_prev;
    assign miss_rise  = miss_q & ~miss_prev;

    // Multiplier is chosen from the combo before this hit is counted.
    assign mult      = (combo < 7'd4) ? 3'd1 : ((combo < 7'd8) ? 3'd2 : 3'd4);
    // One spare bit so the sum cannot wrap before clamping.
    assign score_sum = {1'b0, score} + {12'd0, mult};
    assign combo_inc = (combo >= COMBO_LIM) ? COMBO_LIM : combo + 7'd1;
    assign beat_next = beat_count + 8'd1;
    assign last_life_lost = miss_rise && (lives == 3'd1);

    always_comb begin
        state_d      = state_q;
        score_d      = score;
        combo_d      = combo;
        best_d       = best_combo;
        lives_d      = lives;
        beat_d       = beat_count;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d = PLAY;
                    score_d = '0;
                    combo_d = '0;
                    best_d  = '0;
                    beat_d  = '0;
                    lives_d = LIVES_INI;
                end
            end
            PLAY: begin
                // A miss wins over a simultaneous hit; the hit is dropped.
                if (miss_rise) begin
                    miss_pulse_d = 1'b1;
                    combo_d      = '0;
                    lives_d      = lives - 3'd1;
                    if (last_life_lost) begin
                        state_d = OVER;
                    end
                end else if (hit_rise) begin
                    hit_pulse_d = 1'b1;
                    score_d     = (score_sum > SCORE_LIM) ? SCORE_LIM[13:0] : score_sum[13:0];
                    combo_d     = combo_inc;
                    best_d      = (combo_inc > best_combo) ? combo_inc : best_combo;
                end
                if (met_rise) begin
                    beat_d = beat_next;
                    // Losing the last life on the final beat is a loss, not a win.
                    if ((beat_next == BEATS_END) && !last_life_lost) begin
                        state_d = WIN;
                    end
                end
            end
            default: begin
                // OVER / WIN: counters hold for display until the next start.
                if (start_rise) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            met_s1     <= 1'b0;
            met_s2     <= 1'b0;
            met_prev   <= 1'b0;
            start_s1   <= 1'b0;
            start_s2   <= 1'b0;
            start_prev <= 1'b0;
            hit_q      <= 1'b0;
            hit_prev   <= 1'b0;
            miss_q     <= 1'b0;
            miss_prev  <= 1'b0;
            state_q    <= IDLE;
            score      <= '0;
            combo      <= '0;
            best_combo <= '0;
            lives      <= LIVES_INI;
            beat_count <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            met_s1     <= metronome_clk;
            met_s2     <= met_s1;
            met_prev   <= met_s2;
            start_s1   <= start;
            start_s2   <= start_s1;
            start_prev <= start_s2;
            hit_q      <= correctHit;
            hit_prev   <= hit_q;
            miss_q     <= incorrectHit;
            miss_prev  <= miss_q;
            state_q    <= state_d;
            score      <= score_d;
            combo      <= combo_d;
            best_combo <= best_d;
            lives      <= lives_d;
            beat_count <= beat_d;
            hit_pulse  <= hit_pulse_d;
            miss_pulse <= miss_pulse_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

    localparam int LIVES = 5;
    localparam int SB    = 4;
    localparam int SMAX  = 9999;
    localparam int CMAX  = 99;
    localparam int MAXC  = 32768;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic metronome_clk = 1'b0;
    logic start = 1'b0;
    logic correctHit = 1'b0;
    logic incorrectHit = 1'b0;

    logic [1:0]  state;
    logic [13:0] score;
    logic [6:0]  combo;
    logic [6:0]  best_combo;
    logic [2:0]  lives;
    logic [7:0]  beat_count;
    logic        hit_pulse;
    logic        miss_pulse;

    score_keeper #(
        .LIVES(LIVES), .SONG_BEATS(SB), .SCORE_MAX(SMAX), .COMBO_MAX(CMAX)
    ) dut (
        .clk(clk), .rst(rst), .metronome_clk(metronome_clk), .start(start),
        .correctHit(correctHit), .incorrectHit(incorrectHit),
        .state(state), .score(score), .combo(combo), .best_combo(best_combo),
        .lives(lives), .beat_count(beat_count),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int dut_hits = 0;
    int dut_miss = 0;
    bit cmp_en   = 0;

    // Events scheduled by the stimulus at the cycle where their effect is due.
    bit ev_h [MAXC];
    bit ev_m [MAXC];
    bit ev_b [MAXC];
    bit ev_s [MAXC];

    // Game model: plain integers updated by the game rules.
    int m_state, m_score, m_combo, m_best, m_lives, m_beat;
    bit m_hp, m_mp;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        int mult;
        bit h, m, b, s;
        cyc = cyc + 1;
        m_hp = 0;
        m_mp = 0;
        if (rst) begin
            m_state = 1; m_score = 0; m_combo = 0; m_best = 0;
            m_lives = LIVES; m_beat = 0;
        end else if (cyc < MAXC) begin
            h = ev_h[cyc]; m = ev_m[cyc]; b = ev_b[cyc]; s = ev_s[cyc];
            case (m_state)
                1: if (s) begin
                    m_state = 0; m_score = 0; m_combo = 0; m_best = 0;
                    m_beat = 0; m_lives = LIVES;
                end
                0: begin
                    if (m) begin
                        m_mp = 1;
                        m_combo = 0;
                        m_lives = m_lives - 1;
                        if (m_lives == 0) m_state = 2;
                    end else if (h) begin
                        m_hp = 1;
                        mult = (m_combo < 4) ? 1 : ((m_combo < 8) ? 2 : 4);
                        m_score = (m_score + mult > SMAX) ? SMAX : m_score + mult;
                        m_combo = (m_combo + 1 > CMAX) ? CMAX : m_combo + 1;
                        if (m_combo > m_best) m_best = m_combo;
                    end
                    if (b) begin
                        m_beat = m_beat + 1;
                        if (m_beat == SB && m_state == 0) m_state = 3;
                    end
                end
                default: if (s) m_state = 1;
            endcase
        end
        cmp_en = 1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("state", int'(state), m_state);
            check("score", int'(score), m_score);
            check("combo", int'(combo), m_combo);
            check("best_combo", int'(best_combo), m_best);
            check("lives", int'(lives), m_lives);
            check("beat_count", int'(beat_count), m_beat);
            check("hit_pulse", int'(hit_pulse), int'(m_hp));
            check("miss_pulse", int'(miss_pulse), int'(m_mp));
            if (hit_pulse) dut_hits++;
            if (miss_pulse) dut_miss++;
        end
    end

    // All stimulus tasks are entered and left at a negedge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic verdict(input bit h, input bit m, input int hold);
        correctHit = h;
        incorrectHit = m;
        if (cyc + 2 < MAXC) begin
            if (h) ev_h[cyc + 2] = 1;
            if (m) ev_m[cyc + 2] = 1;
        end
        tick(hold);
        correctHit = 0;
        incorrectHit = 0;
        tick(1);
    endtask

    task automatic beat();
        metronome_clk = 1;
        if (cyc + 3 < MAXC) ev_b[cyc + 3] = 1;
        tick(3);
        metronome_clk = 0;
        tick(3);
    endtask

    task automatic press();
        start = 1;
        if (cyc + 3 < MAXC) ev_s[cyc + 3] = 1;
        tick(3);
        start = 0;
        tick(3);
    endtask

    // Metronome rise and a miss both landing on the same update edge.
    task automatic beat_with_miss();
        metronome_clk = 1;
        if (cyc + 3 < MAXC) ev_b[cyc + 3] = 1;
        tick(1);
        incorrectHit = 1;
        if (cyc + 2 < MAXC) ev_m[cyc + 2] = 1;
        tick(1);
        incorrectHit = 0;
        tick(2);
        metronome_clk = 0;
        tick(3);
    endtask

    initial begin
        tick(1);
        check("reset_state", int'(state), 1);
        check("reset_lives", int'(lives), 5);
        check("reset_score", int'(score), 0);
        tick(1);
        rst = 0;
        tick(2);

        // Start: IDLE -> PLAY, exact edge pinned by the per-cycle compare.
        press();
        check("start_state", int'(state), 0);
        check("start_lives", int'(lives), 5);
        check("start_score", int'(score), 0);

        // Ten hits with a start press in PLAY that must be ignored.
        dut_hits = 0;
        for (int i = 0; i < 10; i++) begin
            verdict(1, 0, 1);
            if (i == 4) press();
        end
        tick(3);
        check("combo10_score", int'(score), 20);
        check("combo10_combo", int'(combo), 10);
        check("combo10_best", int'(best_combo), 10);
        check("combo10_pulses", dut_hits, 10);
        check("combo10_state", int'(state), 0);

        // One miss then three hits.
        verdict(0, 1, 1);
        tick(2);
        check("miss_combo", int'(combo), 0);
        for (int i = 0; i < 3; i++) verdict(1, 0, 1);
        tick(3);
        check("miss_combo3", int'(combo), 3);
        check("miss_best", int'(best_combo), 10);
        check("miss_lives", int'(lives), 4);
        check("miss_score", int'(score), 23);

        // Simultaneous verdicts drain the remaining lives.
        dut_miss = 0;
        for (int i = 0; i < 4; i++) verdict(1, 1, 1);
        tick(2);
        check("over_state", int'(state), 2);
        check("over_lives", int'(lives), 0);
        check("over_score", int'(score), 23);
        check("over_misses", dut_miss, 4);
        verdict(1, 0, 1);
        beat();
        check("over_frozen_score", int'(score), 23);

        // OVER -> IDLE keeps values; a hit in IDLE must not leak into the game.
        press();
        check("idle_state", int'(state), 1);
        check("idle_score", int'(score), 23);
        verdict(1, 0, 1);
        press();
        tick(2);
        check("replay_score", int'(score), 0);
        check("replay_lives", int'(lives), 5);

        // Song end.
        for (int i = 0; i < 4; i++) beat();
        check("win_beats", int'(beat_count), 4);
        check("win_state", int'(state), 3);

        // Final beat coinciding with last-life miss: OVER wins.
        press();
        press();
        for (int i = 0; i < 4; i++) verdict(0, 1, 1);
        for (int i = 0; i < 3; i++) beat();
        beat_with_miss();
        check("tie_state", int'(state), 2);
        check("tie_beats", int'(beat_count), 4);
        check("tie_lives", int'(lives), 0);

        // Held level counts once, then drive to saturation.
        press();
        press();
        dut_hits = 0;
        verdict(1, 0, 50);
        tick(2);
        check("held_pulses", dut_hits, 1);
        check("held_score", int'(score), 1);
        check("held_combo", int'(combo), 1);
        for (int i = 0; i < 2600; i++) verdict(1, 0, 1);
        tick(3);
        check("sat_score", int'(score), 9999);
        check("sat_combo", int'(combo), 99);
        check("sat_best", int'(best_combo), 99);
        check("sat_state", int'(state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
